instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the word-address width of the instruction port.
REQ-002 The block SHALL have parameter WORD_SIZE, default 32, meaning the instruction width.
REQ-003 The block SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-005 The block SHALL have port rst, input, 1, the asynchronous active-low reset.
REQ-006 The block SHALL have port instr_read_address, output, ADDR_W, the current PC, driven to the memory's instruction port.
REQ-007 The block SHALL have port instr_instruction, input, WORD_SIZE, the combinational instruction word returned for instr_read_address.
REQ-008 The block SHALL have port stall, input, 1, which holds the PC and the output register.
REQ-009 The block SHALL have port flush, input, 1, which kills the output-register contents.
REQ-010 The block SHALL have port redirect_valid, input, 1, a branch/jump request.
REQ-011 The block SHALL have port redirect_target, input, ADDR_W, the branch/jump target.
REQ-012 The block SHALL have port halt_req, input, 1, a request to stop fetching.
REQ-013 The block SHALL have port if_id_instr, output, WORD_SIZE, the registered instruction.
REQ-014 The block SHALL have port if_id_pc, output, ADDR_W, the registered PC of if_id_instr.
REQ-015 The block SHALL have port if_id_valid, output, 1, qualifying if_id_instr/if_id_pc.
REQ-016 The block SHALL have port halted, output, 1, high while the FSM is in HALT.

Function
REQ-017 The FSM SHALL have states BOOT, RUN and HALT; BOOT SHALL last exactly one cycle after reset release, then go to RUN, and BOOT SHALL capture nothing (if_id_valid stays 0).
REQ-018 In RUN with no control input asserted, each cycle SHALL capture instr_instruction/PC into if_id_instr/if_id_pc, set if_id_valid=1 and advance PC by 1.
REQ-019 The fetch latency SHALL be one cycle: the word at PC in cycle t appears on if_id_* in cycle t+1.
REQ-020 In RUN the priority SHALL be redirect_valid > halt_req > stall > sequential.
REQ-021 On redirect_valid, PC SHALL load redirect_target and if_id_valid SHALL go to 0 (the in-flight fetch is wrong-path), regardless of stall.
REQ-022 On stall without redirect, PC, if_id_instr and if_id_pc SHALL hold; if_id_valid SHALL hold unless flush is also asserted.
REQ-023 flush SHALL force if_id_valid to 0 next cycle; flush alone SHALL still advance PC, and flush with stall SHALL hold PC.
REQ-024 On halt_req without redirect, the FSM SHALL go to HALT, PC SHALL hold and if_id_valid SHALL go to 0.
REQ-025 In HALT, PC SHALL hold, if_id_valid SHALL be 0 and halted SHALL be 1; only redirect_valid SHALL exit HALT, going to RUN with PC=redirect_target.
REQ-026 PC arithmetic SHALL be modulo 2^ADDR_W (8'hFF+1 = 8'h00), with no error flagged.
REQ-027 instr_read_address SHALL equal the PC register at all times, with no combinational path from inputs.

Reset
REQ-028 While rst=0, the block SHALL hold PC=RESET_PC, FSM=BOOT, if_id_instr=0, if_id_pc=0, if_id_valid=0 and halted=0, asynchronously.
REQ-029 A reset asserted mid-operation SHALL discard all in-flight state within the same cycle; the first valid capture SHALL be 2 cycles after release.

Configuration
REQ-030 When macro INSTR_FETCH_PERF_CNT_EN is defined, the block SHALL add output fetch_count[31:0], reset to 0, incremented once per cycle in which if_id_valid is set to 1, and wrapping at 2^32.
REQ-031 When INSTR_FETCH_PERF_CNT_EN is undefined, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2) and the default ADDR_W/WORD_SIZE constants.
REQ-033 The block SHALL have one sub-module, fetch_pc_reg, owning the PC register, next-PC mux and wrap arithmetic; everything else is in instr_fetch.

Verification
REQ-034 Scenario reset/boot: release reset with a memory model where mem[i]=i -> if_id_valid=0 one cycle, then if_id_pc=0/if_id_instr=0, then 1/1, 2/2.
REQ-035 Scenario redirect: redirect_valid with target 8'h40 while PC=5 -> next cycle if_id_valid=0 and PC=8'h40; the following cycle if_id_pc=8'h40.
REQ-036 Scenario stall+flush: 3-cycle stall at PC=10 -> PC stays 10 and if_id_* hold; flush during the stall -> if_id_valid=0 and PC still 10.
REQ-037 Scenario wrap: redirect to 8'hFE -> captures at 8'hFE, 8'hFF, 8'h00 with no gap.
REQ-038 Scenario halt: halt_req at PC=7 -> halted=1, if_id_valid=0 and PC=7 indefinitely; redirect to 8'h20 -> halted=0 and next capture at if_id_pc=8'h20.
REQ-039 Scenario async reset: assert rst mid-stream between clock edges -> all outputs reset without waiting for clk; with INSTR_FETCH_PERF_CNT_EN defined, fetch_count returns to 0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch block: FSM encoding, PC mux select, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_fetch_pkg;

    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_WORD_SIZE = 32;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    // Select for the next-PC mux inside fetch_pc_reg
    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// PC register with next-PC mux (hold / increment / load target); increment wraps modulo 2^ADDR_W.
// Latency: new PC visible one cycle after the select is presented.
// Backpressure: none; the caller holds the PC by selecting PC_HOLD.
module fetch_pc_reg
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        pc_sel_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next-PC mux; the increment silently wraps at the top of the address space
    always_comb begin
        pc_d = pc_q;
        case (pc_sel_e'(pc_sel_i))
            PC_INC:  pc_d = pc_q + ADDR_W'(1);
            PC_LOAD: pc_d = target_i;
            default: pc_d = pc_q;
        endcase
    end

    // PC register, asynchronously forced to the reset vector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= ADDR_W'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: BOOT/RUN/HALT FSM driving the PC and an IF/ID output register.
// Latency: word addressed in cycle t appears on if_id_* in cycle t+1; first capture 2 cycles after reset.
// Backpressure: stall holds PC and IF/ID register; redirect overrides stall; flush kills if_id_valid.
// Optional: define INSTR_FETCH_PERF_CNT_EN to add the fetch_count output.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int RESET_PC  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [ADDR_W-1:0]    instr_read_address,
    input  logic [WORD_SIZE-1:0] instr_instruction,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 redirect_valid,
    input  logic [ADDR_W-1:0]    redirect_target,
    input  logic                 halt_req,
    output logic [WORD_SIZE-1:0] if_id_instr,
    output logic [ADDR_W-1:0]    if_id_pc,
    output logic                 if_id_valid,
    output logic                 halted
`ifdef INSTR_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          fetch_count
`endif
);

    fetch_state_e          state_q;
    fetch_state_e          state_d;
    logic [1:0]            pc_sel;
    logic                  capture;
    logic                  valid_d;
    logic [ADDR_W-1:0]     pc;
    logic [WORD_SIZE-1:0]  instr_q;
    logic [ADDR_W-1:0]     ifpc_q;
    logic                  valid_q;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .pc_sel_i (pc_sel),
        .target_i (redirect_target),
        .pc_o     (pc)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: BOOT is a single idle cycle; only a redirect leaves HALT
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (redirect_valid) begin
                    state_d = RUN;
                end else if (halt_req) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // FSM outputs: PC select, capture strobe and next valid (redirect > halt > stall > sequential)
    always_comb begin
        pc_sel  = PC_HOLD;
        capture = 1'b0;
        valid_d = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    // The word currently on the bus is wrong-path: drop it
                    pc_sel = PC_LOAD;
                end else if (halt_req) begin
                    pc_sel = PC_HOLD;
                end else if (stall) begin
                    pc_sel  = PC_HOLD;
                    valid_d = valid_q & ~flush;
                end else begin
                    pc_sel  = PC_INC;
                    capture = 1'b1;
                    valid_d = ~flush;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    pc_sel = PC_LOAD;
                end
            end
            default: begin
                pc_sel = PC_HOLD;
            end
        endcase
    end

    // IF/ID output register: data loads only on a sequential fetch, valid follows valid_d
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q <= '0;
            ifpc_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (capture) begin
                instr_q <= instr_instruction;
                ifpc_q  <= pc;
            end
            valid_q <= valid_d;
        end
    end

    assign instr_read_address = pc;
    assign if_id_instr        = instr_q;
    assign if_id_pc           = ifpc_q;
    assign if_id_valid        = valid_q;
    assign halted             = (state_q == HALT);

`ifdef INSTR_FETCH_PERF_CNT_EN
    logic [31:0] count_q;

    // Count every newly delivered valid fetch; wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (capture && valid_d) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a memory model mem[i] = i.
// Inputs change 1ns after posedge; outputs are checked at the same point.
// Each check is an immediate assertion that counts and reports failures.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  instr_read_address;
    logic [31:0] instr_instruction;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_target = 8'h00;
    logic        halt_req = 1'b0;
    logic [31:0] if_id_instr;
    logic [7:0]  if_id_pc;
    logic        if_id_valid;
    logic        halted;
`ifdef INSTR_FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign instr_instruction = {24'h000000, instr_read_address};

    instr_fetch dut (
        .clk                (clk),
        .rst                (rst),
        .instr_read_address (instr_read_address),
        .instr_instruction  (instr_instruction),
        .stall              (stall),
        .flush              (flush),
        .redirect_valid     (redirect_valid),
        .redirect_target    (redirect_target),
        .halt_req           (halt_req),
        .if_id_instr        (if_id_instr),
        .if_id_pc           (if_id_pc),
        .if_id_valid        (if_id_valid),
        .halted             (halted)
`ifdef INSTR_FETCH_PERF_CNT_EN
        ,
        .fetch_count        (fetch_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cap(input string tag, input logic [7:0] p);
        chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd1);
        chk({tag, "_pc"}, {24'd0, if_id_pc}, {24'd0, p});
        chk({tag, "_instr"}, if_id_instr, {24'd0, p});
    endtask

    initial begin
        // Reset held
        tick(); tick();
        chk("rst_pc", {24'd0, instr_read_address}, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_instr", if_id_instr, 32'd0);
        chk("rst_ifpc", {24'd0, if_id_pc}, 32'd0);
        rst = 1'b1;

        // BOOT cycle: nothing captured, PC held
        tick();
        chk("boot_valid", {31'd0, if_id_valid}, 32'd0);
        chk("boot_pc", {24'd0, instr_read_address}, 32'd0);
        tick(); chk_cap("seq0", 8'd0);
        chk("seq0_addr", {24'd0, instr_read_address}, 32'd1);
        tick(); chk_cap("seq1", 8'd1);
        tick(); chk_cap("seq2", 8'd2);
        tick(); chk_cap("seq3", 8'd3);
        tick(); chk_cap("seq4", 8'd4);
        chk("pc5", {24'd0, instr_read_address}, 32'd5);

        // Redirect to 0x40 at PC=5
        redirect_valid = 1'b1; redirect_target = 8'h40;
        tick();
        redirect_valid = 1'b0;
        chk("redir_valid", {31'd0, if_id_valid}, 32'd0);
        chk("redir_pc", {24'd0, instr_read_address}, 32'h40);
        tick(); chk_cap("redir_cap", 8'h40);

        // Get to PC=10 with a valid word for PC 9 in IF/ID
        redirect_valid = 1'b1; redirect_target = 8'd9;
        tick();
        redirect_valid = 1'b0;
        tick(); chk_cap("pre_stall", 8'd9);
        chk("pre_stall_addr", {24'd0, instr_read_address}, 32'd10);

        // Three-cycle stall
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cap("stall_hold", 8'd9);
            chk("stall_addr", {24'd0, instr_read_address}, 32'd10);
        end
        // Flush during stall
        flush = 1'b1;
        tick();
        chk("stflush_valid", {31'd0, if_id_valid}, 32'd0);
        chk("stflush_addr", {24'd0, instr_read_address}, 32'd10);
        chk("stflush_ifpc", {24'd0, if_id_pc}, 32'd9);
        stall = 1'b0; flush = 1'b0;
        tick(); chk_cap("post_stall", 8'd10);
        // Flush alone advances PC
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", {31'd0, if_id_valid}, 32'd0);
        chk("flush_addr", {24'd0, instr_read_address}, 32'd12);
        tick(); chk_cap("post_flush", 8'd12);

        // Wrap around the top of the address space
        redirect_valid = 1'b1; redirect_target = 8'hFE;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_gap", {31'd0, if_id_valid}, 32'd0);
        tick(); chk_cap("wrap_fe", 8'hFE);
        tick(); chk_cap("wrap_ff", 8'hFF);
        tick(); chk_cap("wrap_00", 8'h00);
        chk("wrap_addr", {24'd0, instr_read_address}, 32'd1);

        // Halt at PC=7
        redirect_valid = 1'b1; redirect_target = 8'd7;
        tick();
        redirect_valid = 1'b0;
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("halt_halted", {31'd0, halted}, 32'd1);
            chk("halt_valid", {31'd0, if_id_valid}, 32'd0);
            chk("halt_addr", {24'd0, instr_read_address}, 32'd7);
            tick();
        end
        redirect_valid = 1'b1; redirect_target = 8'h20;
        tick();
        redirect_valid = 1'b0;
        chk("unhalt_halted", {31'd0, halted}, 32'd0);
        chk("unhalt_addr", {24'd0, instr_read_address}, 32'h20);
        chk("unhalt_valid", {31'd0, if_id_valid}, 32'd0);
        tick(); chk_cap("unhalt_cap", 8'h20);
        tick(); chk_cap("unhalt_cap2", 8'h21);

        // Redirect wins over halt and stall
        redirect_valid = 1'b1; redirect_target = 8'h30; halt_req = 1'b1; stall = 1'b1;
        tick();
        redirect_valid = 1'b0; halt_req = 1'b0; stall = 1'b0;
        chk("prio_halted", {31'd0, halted}, 32'd0);
        chk("prio_addr", {24'd0, instr_read_address}, 32'h30);
        chk("prio_valid", {31'd0, if_id_valid}, 32'd0);
        tick(); chk_cap("prio_cap", 8'h30);
`ifdef INSTR_FETCH_PERF_CNT_EN
        chk("cnt_before_rst", fetch_count, 32'd15);
`endif

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("arst_ifpc", {24'd0, if_id_pc}, 32'd0);
        chk("arst_instr", if_id_instr, 32'd0);
        chk("arst_addr", {24'd0, instr_read_address}, 32'd0);
        chk("arst_halted", {31'd0, halted}, 32'd0);
`ifdef INSTR_FETCH_PERF_CNT_EN
        chk("arst_cnt", fetch_count, 32'd0);
`endif
        tick();
        rst = 1'b1;
        tick();
        chk("reboot_valid", {31'd0, if_id_valid}, 32'd0);
        tick(); chk_cap("reboot_cap", 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
